// File: rtl/microwave_time_entry_if.sv
// Parallel-load / enable / zero link between the time-entry front end and the countdown counter.
interface microwave_time_entry_if;
   logic [3:0] uni_sec;
   logic [3:0] dez_sec;
   logic [3:0] min;
   logic       load;
   logic       enable;
   logic       zero;

   modport master (output uni_sec, dez_sec, min, load, enable, input zero);
   modport slave  (input uni_sec, dez_sec, min, load, enable, output zero);
endinterface

// File: rtl/microwave_time_entry.sv
// Microwave keypad time entry: shifts M:SS digits, validates START, loads and enables the countdown.
// Optional macro QUICK_START_EN: START in IDLE/DONE loads 0:30 and starts cooking.
module microwave_time_entry #(
   parameter int unsigned DONE_CYCLES = 4,
   parameter int unsigned KEY_W       = 4
) (
   input  logic                      clk,
   input  logic                      clear,
   input  logic                      key_valid,
   input  logic [KEY_W-1:0]          key_code,
   microwave_time_entry_if.master    ctr,
   output logic                      done,
   output logic                      err,
   output logic [1:0]                digit_cnt
);

   localparam int unsigned DIG_W  = 4;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned HOLD_W = 4;

   localparam logic [KEY_W-1:0]  KEY_LAST_DIGIT = KEY_W'(9);
   localparam logic [KEY_W-1:0]  KEY_START      = KEY_W'(10);
   localparam logic [KEY_W-1:0]  KEY_CANCEL     = KEY_W'(11);
   localparam logic [CNT_W-1:0]  CNT_MAX        = CNT_W'(3);
   localparam logic [HOLD_W-1:0] HOLD_LAST      = HOLD_W'(DONE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DIG_W-1:0]   uni_q, uni_d;
   logic [DIG_W-1:0]   dez_q, dez_d;
   logic [DIG_W-1:0]   min_q, min_d;
   logic               load_q, load_d;
   logic               enable_q, enable_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic               is_digit_c;
   logic               is_start_c;
   logic               is_cancel_c;
   logic [DIG_W-1:0]   key_digit_c;

   assign is_digit_c  = key_valid && (key_code <= KEY_LAST_DIGIT);
   assign is_start_c  = key_valid && (key_code == KEY_START);
   assign is_cancel_c = key_valid && (key_code == KEY_CANCEL);
   assign key_digit_c = DIG_W'(key_code);

   // State and all outputs registered together; clear aborts anything in flight.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= S_IDLE;
         uni_q    <= '0;
         dez_q    <= '0;
         min_q    <= '0;
         load_q   <= 1'b0;
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         uni_q    <= uni_d;
         dez_q    <= dez_d;
         min_q    <= min_d;
         load_q   <= load_d;
         enable_q <= enable_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
      end
   end

   // Next state and next output values; pulses default low, digits hold.
   always_comb begin
      state_d  = state_q;
      uni_d    = uni_q;
      dez_d    = dez_q;
      min_d    = min_q;
      load_d   = 1'b0;
      enable_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      hold_d   = hold_q;

      unique case (state_q)
         S_IDLE: begin
            if (is_digit_c) begin
               uni_d   = key_digit_c;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = CNT_W'(1);
               state_d = S_ENTRY;
            end
`ifdef QUICK_START_EN
            else if (is_start_c) begin
               uni_d   = '0;
               dez_d   = DIG_W'(3);
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
`endif
         end

         S_ENTRY: begin
            if (is_digit_c) begin
               min_d = dez_q;
               dez_d = uni_q;
               uni_d = key_digit_c;
               cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            end else if (is_cancel_c) begin
               uni_d   = '0;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (is_start_c) begin
               if ((dez_q > DIG_W'(5)) || ({min_q, dez_q, uni_q} == '0)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            load_d  = 1'b1;
            state_d = S_RUN;
         end

         // enable_q is still low on the first RUN cycle, which masks the settling zero flag.
         S_RUN: begin
            if (is_cancel_c) begin
               uni_d   = '0;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (enable_q && ctr.zero) begin
               done_d  = 1'b1;
               hold_d  = '0;
               state_d = S_DONE;
            end else begin
               enable_d = 1'b1;
            end
         end

         S_DONE: begin
            if (is_digit_c) begin
               uni_d   = key_digit_c;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = CNT_W'(1);
               state_d = S_ENTRY;
            end else if (is_cancel_c) begin
               uni_d   = '0;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
`ifdef QUICK_START_EN
            else if (is_start_c) begin
               uni_d   = '0;
               dez_d   = DIG_W'(3);
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
`endif
            else if (hold_q == HOLD_LAST) begin
               uni_d   = '0;
               dez_d   = '0;
               min_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               done_d = 1'b1;
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ctr.uni_sec = uni_q;
   assign ctr.dez_sec = dez_q;
   assign ctr.min     = min_q;
   assign ctr.load    = load_q;
   assign ctr.enable  = enable_q;
   assign done        = done_q;
   assign err         = err_q;
   assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_microwave_time_entry.sv
// Self-checking bench: directed scenarios plus random keys against a queue-based reference model.
module tb_microwave_time_entry;
   localparam int unsigned DONE_CYCLES = 4;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       zero = 1'b0;
   logic       done;
   logic       err;
   logic [1:0] digit_cnt;

   microwave_time_entry_if ctr_if ();
   assign ctr_if.zero = zero;

   microwave_time_entry #(.DONE_CYCLES(DONE_CYCLES), .KEY_W(4)) dut (
      .clk       (clk),
      .clear     (clear),
      .key_valid (key_valid),
      .key_code  (key_code),
      .ctr       (ctr_if),
      .done      (done),
      .err       (err),
      .digit_cnt (digit_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: entered digits as a queue (oldest first), plus a coarse phase.
   localparam int PH_IDLE  = 0;
   localparam int PH_ENTRY = 1;
   localparam int PH_LOAD  = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_DONE  = 4;

   int m_q[$];
   int m_cnt;
   int m_phase;
   int m_hold;
   bit m_load, m_en, m_done, m_err;

   function automatic int m_digit(int pos);
      if (pos < m_q.size()) return m_q[m_q.size() - 1 - pos];
      return 0;
   endfunction

   task automatic m_wipe();
      m_q.delete();
      m_cnt = 0;
   endtask

   task automatic model_clear();
      m_wipe();
      m_phase = PH_IDLE;
      m_hold  = 0;
      m_load  = 0;
      m_en    = 0;
      m_done  = 0;
      m_err   = 0;
   endtask

   task automatic m_quick();
      m_q.delete();
      m_q.push_back(0);
      m_q.push_back(3);
      m_q.push_back(0);
      m_cnt   = 0;
      m_phase = PH_LOAD;
   endtask

   task automatic m_first_digit(int kc);
      m_q.delete();
      m_q.push_back(kc);
      m_cnt   = 1;
      m_phase = PH_ENTRY;
   endtask

   task automatic model_edge(bit kv, int kc, bit z);
      bit dig = kv && (kc <= 9);
      bit st  = kv && (kc == 10);
      bit cn  = kv && (kc == 11);
      bit quick = 0;
      int total;
`ifdef QUICK_START_EN
      quick = 1;
`endif
      m_load = 0;
      m_err  = 0;
      case (m_phase)
         PH_IDLE: begin
            if (dig) m_first_digit(kc);
            else if (quick && st) m_quick();
         end
         PH_ENTRY: begin
            if (dig) begin
               m_q.push_back(kc);
               if (m_q.size() > 3) void'(m_q.pop_front());
               m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            end else if (cn) begin
               m_wipe();
               m_phase = PH_IDLE;
            end else if (st) begin
               total = m_digit(2) * 60 + m_digit(1) * 10 + m_digit(0);
               if (m_digit(1) > 5 || total == 0) m_err = 1;
               else m_phase = PH_LOAD;
            end
         end
         PH_LOAD: begin
            m_load  = 1;
            m_phase = PH_RUN;
         end
         PH_RUN: begin
            if (cn) begin
               m_wipe();
               m_en    = 0;
               m_phase = PH_IDLE;
            end else if (m_en && z) begin
               m_en    = 0;
               m_done  = 1;
               m_hold  = DONE_CYCLES - 1;
               m_phase = PH_DONE;
            end else begin
               m_en = 1;
            end
         end
         default: begin
            if (dig) begin
               m_done = 0;
               m_first_digit(kc);
            end else if (cn) begin
               m_done = 0;
               m_wipe();
               m_phase = PH_IDLE;
            end else if (quick && st) begin
               m_done = 0;
               m_quick();
            end else if (m_hold == 0) begin
               m_done = 0;
               m_wipe();
               m_phase = PH_IDLE;
            end else begin
               m_hold--;
            end
         end
      endcase
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("uni_sec", 32'(ctr_if.uni_sec), 32'(m_digit(0)));
      chk("dez_sec", 32'(ctr_if.dez_sec), 32'(m_digit(1)));
      chk("min", 32'(ctr_if.min), 32'(m_digit(2)));
      chk("load", 32'(ctr_if.load), 32'(m_load));
      chk("enable", 32'(ctr_if.enable), 32'(m_en));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
   endtask

   task automatic tick(bit kv, int kc, bit z);
      key_valid = kv;
      key_code  = 4'(kc);
      zero      = z;
      @(posedge clk);
      model_edge(kv, kc, z);
      #1;
      check_all();
      key_valid = 1'b0;
      zero      = 1'b0;
   endtask

   task automatic press(int kc);
      tick(1'b1, kc, 1'b0);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
   endtask

   task automatic do_clear();
      #2;
      clear = 1'b1;
      #1;
      model_clear();
      check_all();
      clear = 1'b0;
   endtask

   int done_len;

   initial begin
      model_clear();
      #1 clear = 1'b1;
      #2 check_all();
      chk("reset_enable", 32'(ctr_if.enable), 32'd0);
      #4 clear = 1'b0;

      // Basic entry with load/enable latency, then clear mid-RUN.
      press(1); press(3); press(0);
      chk("entry_min", 32'(ctr_if.min), 32'd1);
      chk("entry_dez", 32'(ctr_if.dez_sec), 32'd3);
      chk("entry_cnt", 32'(digit_cnt), 32'd3);
      press(10);
      chk("load_at_n", 32'(ctr_if.load), 32'd0);
      idle(1);
      chk("load_at_n1", 32'(ctr_if.load), 32'd1);
      chk("en_at_n1", 32'(ctr_if.enable), 32'd0);
      idle(1);
      chk("load_at_n2", 32'(ctr_if.load), 32'd0);
      chk("en_at_n2", 32'(ctr_if.enable), 32'd1);
      idle(3);
      do_clear();
      chk("clear_enable", 32'(ctr_if.enable), 32'd0);
      chk("clear_uni", 32'(ctr_if.uni_sec), 32'd0);

      // Overflow drops the oldest digit.
      press(1); press(2); press(3); press(4);
      chk("ovf_min", 32'(ctr_if.min), 32'd2);
      chk("ovf_uni", 32'(ctr_if.uni_sec), 32'd4);
      chk("ovf_cnt", 32'(digit_cnt), 32'd3);
      press(11);

      // Rejected starts: tens above 5, and all-zero time.
      press(7); press(5); press(10);
      chk("rej_err", 32'(err), 32'd1);
      idle(2);
      chk("rej_err_gone", 32'(err), 32'd0);
      chk("rej_dez", 32'(ctr_if.dez_sec), 32'd7);
      press(11);
      chk("cancel_uni", 32'(ctr_if.uni_sec), 32'd0);
      press(0); press(10);
      chk("zero_err", 32'(err), 32'd1);
      press(11);

      // Completion: done held for DONE_CYCLES cycles.
      press(0); press(5); press(10); idle(2);
      tick(1'b0, 0, 1'b1);
      chk("zero_en_off", 32'(ctr_if.enable), 32'd0);
      done_len = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1) done_len++;
         idle(1);
      end
      chk("done_len", 32'(done_len), 32'(DONE_CYCLES));

      // Digit key aborts the done hold.
      press(9); press(10); idle(2);
      tick(1'b0, 0, 1'b1);
      press(7);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_uni", 32'(ctr_if.uni_sec), 32'd7);
      press(11);

      // CANCEL and zero together: cancel wins.
      press(2); press(10); idle(3);
      tick(1'b1, 11, 1'b1);
      chk("coll_done", 32'(done), 32'd0);
      chk("coll_en", 32'(ctr_if.enable), 32'd0);
      idle(1);

      // START from IDLE.
      press(10); idle(1);
`ifdef QUICK_START_EN
      chk("qs_load", 32'(ctr_if.load), 32'd1);
      chk("qs_dez", 32'(ctr_if.dez_sec), 32'd3);
`else
      chk("qs_load", 32'(ctr_if.load), 32'd0);
      chk("qs_dez", 32'(ctr_if.dez_sec), 32'd0);
`endif
      press(11); idle(1);

      // Random keys, zero flags and occasional clears.
      for (int i = 0; i < 600; i++) begin
         int r = $urandom_range(0, 99);
         if (r < 2) begin
            do_clear();
         end else if (r < 40) begin
            int sel = $urandom_range(0, 9);
            int kc = (sel < 6) ? $urandom_range(0, 9) :
                     (sel < 8) ? 10 : (sel < 9) ? 11 : $urandom_range(12, 15);
            tick(1'b1, kc, ($urandom_range(0, 5) == 0));
         end else begin
            tick(1'b0, 0, ($urandom_range(0, 5) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
